// File: rtl/stepper_pkg.sv
// Shared types and helpers for the multi-axis step/direction generator.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } axis_state_e;

    // The period never drops below twice the pulse width, so LOW is at least as long as HIGH.
    function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                                 input logic [31:0] pulse_cycles);
        logic [31:0] min_p;
        min_p = pulse_cycles << 1;
        return (period < min_p) ? min_p : period;
    endfunction

endpackage

// File: rtl/stepper_axes_if.sv
// Relative-move command channel: one command per cycle, valid/ready transfer.
interface stepper_axes_if #(
    parameter int CHANNELS     = 4,
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 25
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                    cmd_valid_in;
    logic                    cmd_ready_out;
    logic [CH_W-1:0]         cmd_channel_in;
    logic [POS_WIDTH-1:0]    cmd_steps_in;
    logic [PERIOD_WIDTH-1:0] cmd_period_in;

    modport master (
        output cmd_valid_in, cmd_channel_in, cmd_steps_in, cmd_period_in,
        input  cmd_ready_out
    );

    modport slave (
        input  cmd_valid_in, cmd_channel_in, cmd_steps_in, cmd_period_in,
        output cmd_ready_out
    );
endinterface

// File: rtl/stepper_axes_step_channel.sv
// One axis: direction setup, timed STEP pulses, remaining-step count and absolute position.
module step_channel
    import stepper_pkg::*;
#(
    parameter int POS_WIDTH    = 32,
    parameter int PULSE_CYCLES = 50,
    parameter int DIR_SETUP    = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 accept,
    input  logic [POS_WIDTH-1:0] steps,
    input  logic [31:0]          period,
    input  logic                 abort,
    output logic                 step,
    output logic                 dir,
    output logic                 busy,
    output logic                 done,
    output logic [POS_WIDTH-1:0] position
);
    localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);
    localparam logic [31:0] HIGH_LOAD  = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] PULSE_LEN  = 32'(PULSE_CYCLES);

    axis_state_e          state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          per_q, per_d;
    logic [POS_WIDTH-1:0] rem_q, rem_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 done_q, done_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 do_rise, go_idle;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        per_d        = per_q;
        rem_d        = rem_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        abort_pend_d = abort_pend_q;
        do_rise      = 1'b0;
        go_idle      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (accept) begin
                    dir_d = !steps[POS_WIDTH-1];
                    if (steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                        per_d   = period;
                        // Magnitude as unsigned, so the most negative count is still a legal move.
                        rem_d   = steps[POS_WIDTH-1] ? (POS_WIDTH'(0) - steps) : steps;
                    end
                end
            end
            ST_SETUP: begin
                if (abort)              go_idle = 1'b1;
                else if (cnt_q == '0)   do_rise = 1'b1;
                else                    cnt_d   = cnt_q - 32'd1;
            end
            ST_HIGH: begin
                // An abort here is remembered so the pulse still gets its full high time.
                if (abort) abort_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    if (abort_pend_q || abort) begin
                        go_idle = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = per_q - PULSE_LEN - 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_LOW: begin
                if (abort)                go_idle = 1'b1;
                else if (cnt_q != '0)     cnt_d   = cnt_q - 32'd1;
                else if (rem_q == '0)     go_idle = 1'b1;
                else                      do_rise = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_rise) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
            rem_d   = rem_q - POS_WIDTH'(1);
            pos_d   = dir_q ? (pos_q + POS_WIDTH'(1)) : (pos_q - POS_WIDTH'(1));
        end
        if (go_idle) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            per_q        <= '0;
            rem_q        <= '0;
            pos_q        <= '0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            rem_q        <= rem_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign step     = (state_q == ST_HIGH);
    assign busy     = (state_q != ST_IDLE);
    assign dir      = dir_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule

// File: rtl/stepper_axes.sv
// Multi-axis step/direction pulse generator: command decode and per-axis channel array.
module stepper_axes
    import stepper_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 25,
    parameter int PULSE_CYCLES = 50,
    parameter int DIR_SETUP    = 25
) (
    input  logic                          clk_in,
    input  logic                          reset_n_in,
    stepper_axes_if.slave                 cmd,
    input  logic [CHANNELS-1:0]           abort_in,
    output logic [CHANNELS-1:0]           step_out,
    output logic [CHANNELS-1:0]           dir_out,
    output logic [CHANNELS-1:0]           busy_out,
    output logic [CHANNELS-1:0]           done_out,
    output logic [CHANNELS*POS_WIDTH-1:0] position_out
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                ready;
    logic [CHANNELS-1:0] accept;
    logic [31:0]         eff_period;

    // Channel indices beyond CHANNELS never match, which keeps ready low for them.
    always_comb begin
        ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cmd.cmd_channel_in == CH_W'(i)) ready = !busy_out[i] && !abort_in[i];
        end
        ready = ready && reset_n_in;
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = cmd.cmd_valid_in && ready && (cmd.cmd_channel_in == CH_W'(i));
        end
    end

    assign cmd.cmd_ready_out = ready;
    assign eff_period = clamp_period(32'(cmd.cmd_period_in), 32'(PULSE_CYCLES));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        step_channel #(
            .POS_WIDTH   (POS_WIDTH),
            .PULSE_CYCLES(PULSE_CYCLES),
            .DIR_SETUP   (DIR_SETUP)
        ) u_ch (
            .clk     (clk_in),
            .rst_n   (reset_n_in),
            .accept  (accept[g]),
            .steps   (cmd.cmd_steps_in),
            .period  (eff_period),
            .abort   (abort_in[g]),
            .step    (step_out[g]),
            .dir     (dir_out[g]),
            .busy    (busy_out[g]),
            .done    (done_out[g]),
            .position(position_out[g*POS_WIDTH +: POS_WIDTH])
        );
    end

endmodule
